// File: rtl/pipeline_arbiter_if.sv
// Requester-side and head-stage-side signal bundle of the pipeline arbiter.
// The master modport is the arbiter itself. The slave modport is the
// environment: the requesters, the flush source and the head pipeline stage.
interface pipeline_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) ();
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         req_stall;
    logic                     flush_req;
    logic                     pipe_out_stall;
    logic [DATA_W-1:0]        pipe_inputs;
    logic                     pipe_in_valid;
    logic                     pipe_in_flush;
    logic [$clog2(N_REQ)-1:0] grant_id;
    logic                     flush_done;

    modport master (
        input  req_valid, req_data, flush_req, pipe_out_stall,
        output req_stall, pipe_inputs, pipe_in_valid, pipe_in_flush,
               grant_id, flush_done
    );

    modport slave (
        output req_valid, req_data, flush_req, pipe_out_stall,
        input  req_stall, pipe_inputs, pipe_in_valid, pipe_in_flush,
               grant_id, flush_done
    );
endinterface

// File: rtl/pipeline_arbiter.sv
// Round-robin burst arbiter and flush sequencer feeding the head stage of a
// stall-aware pipeline chain. Data, valid and grant are combinational from the
// requesters (zero-cycle latency); flush and flush_done come from registers.
module pipeline_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 32,
    parameter int BURST       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    pipeline_arbiter_if.master bus
);
    localparam int IDX_W  = $clog2(N_REQ);
    localparam int BCNT_W = $clog2(BURST + 1);
    localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(BURST);
    localparam logic [HCNT_W-1:0] HOLD_INIT = HCNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic               owner_vld;
    logic [BCNT_W-1:0]  burst_cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [HCNT_W-1:0]  hold_cnt;
    logic               flush_done;
    // Distinguishes a hold window entered from FLUSH (pulse flush_done on
    // exit) from the one the block wakes up in after reset (no pulse).
    logic               from_flush;

    logic [DATA_W-1:0]  data_arr [N_REQ];
    logic [IDX_W-1:0]   rr_pick;
    logic [IDX_W-1:0]   cur;
    logic               xfer;
    logic               new_burst;
    logic [BCNT_W-1:0]  n_cnt;
    logic               owner_drop;

    // Next index modulo N_REQ; works for any N_REQ, not only powers of two.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // First valid requester searching upward from start with wrap; start if none.
    function automatic logic [IDX_W-1:0] rr_search(input logic [N_REQ-1:0] valid,
                                                   input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // Grant candidate selection and burst-count arithmetic for this cycle.
    always_comb begin
        rr_pick    = rr_search(bus.req_valid, rr_ptr);
        cur        = (owner_vld && bus.req_valid[owner]) ? owner : rr_pick;
        xfer       = (state == RUN) && bus.req_valid[cur] && !bus.pipe_out_stall;
        new_burst  = !owner_vld || (cur != owner);
        n_cnt      = new_burst ? BCNT_W'(1) : burst_cnt + 1'b1;
        owner_drop = owner_vld && !bus.req_valid[owner];
    end

    assign bus.pipe_inputs   = data_arr[cur];
    assign bus.pipe_in_valid = (state == RUN) && bus.req_valid[cur];
    assign bus.pipe_in_flush = (state == FLUSH);
    assign bus.grant_id      = cur;
    assign bus.flush_done    = flush_done;
    assign bus.req_stall     = bus.req_valid & ~(xfer ? (N_REQ'(1) << cur) : '0);

    // Flush FSM together with the round-robin ownership and burst bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            owner      <= '0;
            owner_vld  <= 1'b0;
            burst_cnt  <= '0;
            rr_ptr     <= '0;
            flush_done <= 1'b0;
            from_flush <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (xfer) begin
                        if (n_cnt == BURST_MAX) begin
                            owner_vld <= 1'b0;
                            burst_cnt <= '0;
                            rr_ptr    <= wrap_inc(cur);
                        end else begin
                            owner     <= cur;
                            owner_vld <= 1'b1;
                            burst_cnt <= n_cnt;
                        end
                    end else if (owner_drop) begin
                        owner_vld <= 1'b0;
                        burst_cnt <= '0;
                        rr_ptr    <= wrap_inc(owner);
                    end
                    // The transfer above still completes; the flush then
                    // overrides the arbitration state.
                    if (bus.flush_req) begin
                        state     <= FLUSH;
                        owner_vld <= 1'b0;
                        burst_cnt <= '0;
                        rr_ptr    <= '0;
                    end
                end
                FLUSH: begin
                    if (!bus.flush_req) begin
                        state      <= HOLD;
                        hold_cnt   <= HOLD_INIT;
                        from_flush <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.flush_req) begin
                        state     <= FLUSH;
                        owner_vld <= 1'b0;
                        burst_cnt <= '0;
                        rr_ptr    <= '0;
                    end else if (hold_cnt == '0) begin
                        state      <= RUN;
                        flush_done <= from_flush;
                        from_flush <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed bench for pipeline_arbiter: a default instance (BURST=4,
// HOLD_CYCLES=2) and a BURST=1 instance, both with four requesters.
module tb_pipeline_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_arbiter_if #(.N_REQ(4), .DATA_W(32)) bus_a ();
    pipeline_arbiter_if #(.N_REQ(4), .DATA_W(8))  bus_b ();

    pipeline_arbiter #(.N_REQ(4), .DATA_W(32), .BURST(4), .HOLD_CYCLES(2)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pipeline_arbiter #(.N_REQ(4), .DATA_W(8), .BURST(1), .HOLD_CYCLES(2)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle of instance A at the falling edge, then move past the next rising edge.
    task automatic cyc_a(input string tag, input logic vld, input logic [1:0] gid,
                         input logic [3:0] rs, input logic fl, input logic done);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(bus_a.pipe_in_valid), 32'(vld));
        chk({tag, ".grant"}, 32'(bus_a.grant_id),      32'(gid));
        chk({tag, ".stall"}, 32'(bus_a.req_stall),     32'(rs));
        chk({tag, ".flush"}, 32'(bus_a.pipe_in_flush), 32'(fl));
        chk({tag, ".done"},  32'(bus_a.flush_done),    32'(done));
        if (vld) chk({tag, ".data"}, bus_a.pipe_inputs, 32'hD0 + 32'(gid));
        @(posedge clk);
        #1;
    endtask

    // A cycle of instance A that transfers from requester g with no flush activity.
    task automatic grant_a(input string tag, input logic [1:0] g);
        logic [3:0] one;
        one = 4'b0001 << g;
        cyc_a(tag, 1'b1, g, bus_a.req_valid & ~one, 1'b0, 1'b0);
    endtask

    task automatic cyc_b(input string tag, input logic [1:0] gid,
                         input logic [3:0] rs, input logic [7:0] data);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(bus_b.pipe_in_valid), 32'd1);
        chk({tag, ".grant"}, 32'(bus_b.grant_id),      32'(gid));
        chk({tag, ".stall"}, 32'(bus_b.req_stall),     32'(rs));
        chk({tag, ".data"},  32'(bus_b.pipe_inputs),   32'(data));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        reset                = 1'b1;
        bus_a.req_valid      = 4'hF;
        bus_a.req_data       = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        bus_a.flush_req      = 1'b0;
        bus_a.pipe_out_stall = 1'b0;
        bus_b.req_valid      = 4'h0;
        bus_b.req_data       = {8'h33, 8'h22, 8'h11, 8'h00};
        bus_b.flush_req      = 1'b0;
        bus_b.pipe_out_stall = 1'b0;

        // Held in reset: everything quiet, all valid requesters stalled.
        cyc_a("rst", 1'b0, 2'd0, 4'hF, 1'b0, 1'b0);
        reset = 1'b0;
        // First cycle after release is still HOLD.
        cyc_a("hold_rel", 1'b0, 2'd0, 4'hF, 1'b0, 1'b0);
        // Four to requester 0 then four to requester 1; no flush_done after reset.
        for (int k = 0; k < 8; k++) begin
            g = (k < 4) ? 2'd0 : 2'd1;
            grant_a("burst01", g);
        end

        // Requester 2 reaches burst_cnt=2, then the head stage stalls 3 cycles.
        grant_a("r2_a", 2'd2);
        grant_a("r2_b", 2'd2);
        bus_a.pipe_out_stall = 1'b1;
        for (int k = 0; k < 3; k++) cyc_a("stall_hold", 1'b1, 2'd2, 4'hF, 1'b0, 1'b0);
        bus_a.pipe_out_stall = 1'b0;
        grant_a("r2_c", 2'd2);
        grant_a("r2_d", 2'd2);
        for (int k = 0; k < 4; k++) grant_a("r3", 2'd3);

        // Owner 0 drops after two transfers; requester 1 takes over the same cycle.
        bus_a.req_valid = 4'b0111;
        grant_a("r0_a", 2'd0);
        grant_a("r0_b", 2'd0);
        bus_a.req_valid = 4'b0110;
        for (int k = 0; k < 4; k++) grant_a("r1_take", 2'd1);
        grant_a("rr_at_2", 2'd2);

        // One-cycle flush request in RUN: that cycle's transfer still happens.
        bus_a.flush_req = 1'b1;
        grant_a("flush_run", 2'd2);
        bus_a.flush_req = 1'b0;
        cyc_a("flush", 1'b0, 2'd1, 4'b0110, 1'b1, 1'b0);
        cyc_a("hold1", 1'b0, 2'd1, 4'b0110, 1'b0, 1'b0);
        cyc_a("hold2", 1'b0, 2'd1, 4'b0110, 1'b0, 1'b0);
        cyc_a("done",  1'b1, 2'd1, 4'b0100, 1'b0, 1'b1);
        cyc_a("after", 1'b1, 2'd1, 4'b0100, 1'b0, 1'b0);

        // Flush request pulsed during HOLD restarts the sequence.
        bus_a.flush_req = 1'b1;
        grant_a("flush_run2", 2'd1);
        bus_a.flush_req = 1'b0;
        cyc_a("flush2", 1'b0, 2'd1, 4'b0110, 1'b1, 1'b0);
        bus_a.flush_req = 1'b1;
        cyc_a("hold_pulse", 1'b0, 2'd1, 4'b0110, 1'b0, 1'b0);
        bus_a.flush_req = 1'b0;
        cyc_a("reflush", 1'b0, 2'd1, 4'b0110, 1'b1, 1'b0);
        cyc_a("rehold1", 1'b0, 2'd1, 4'b0110, 1'b0, 1'b0);
        cyc_a("rehold2", 1'b0, 2'd1, 4'b0110, 1'b0, 1'b0);
        cyc_a("redone",  1'b1, 2'd1, 4'b0100, 1'b0, 1'b1);

        // Reset mid-burst takes effect at once; no flush_done on the way back.
        reset = 1'b1;
        cyc_a("rst_mid", 1'b0, 2'd1, 4'b0110, 1'b0, 1'b0);
        reset = 1'b0;
        cyc_a("rst_hold", 1'b0, 2'd1, 4'b0110, 1'b0, 1'b0);
        cyc_a("rst_run",  1'b1, 2'd1, 4'b0100, 1'b0, 1'b0);

        // BURST=1: requesters 1 and 3 alternate every transfer.
        bus_b.req_valid = 4'b1010;
        cyc_b("b1_a", 2'd1, 4'b1000, 8'h11);
        cyc_b("b3_a", 2'd3, 4'b0010, 8'h33);
        cyc_b("b1_b", 2'd1, 4'b1000, 8'h11);
        cyc_b("b3_b", 2'd3, 4'b0010, 8'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_arbiter.md
# pipeline_arbiter

Round-robin arbiter and flush sequencer at the head of a stall-aware pipeline chain. It shares the chain's single input port among `N_REQ` requesters and grants bursts of up to `BURST` transfers. It honours the head stage's `out_stall` back-pressure and generates the chain's `in_flush`, followed by a quiet hold window. It sits between the requesters and the first pipeline stage.

## Interface
- `N_REQ`, default 4: number of requesters; must be at least 2.
- `DATA_W`, default 32: data width, matching the pipeline stage data width.
- `BURST`, default 4: maximum consecutive transfers per grant; must be at least 1.
- `HOLD_CYCLES`, default 2: cycles of forced idle after a flush pulse; must be at least 1.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input `N_REQ`: requester i holds data ready.
- `req_data` input `N_REQ*DATA_W`: requester i data at bits `[i*DATA_W +: DATA_W]`.
- `req_stall` output `N_REQ`: requester i must hold its data this cycle.
- `flush_req` input 1: level flush request, sampled each rising edge.
- `pipe_out_stall` input 1: head stage buffer full; connects to the head stage's `out_stall`.
- `pipe_inputs` output `DATA_W`: data to the head stage.
- `pipe_in_valid` output 1: head-stage valid.
- `pipe_in_flush` output 1: head-stage flush.
- `grant_id` output `clog2(N_REQ)`: index of the current grant candidate `cur`.
- `flush_done` output 1: one-cycle pulse on the first RUN cycle after a flush.

## Operation
- FSM states are RUN, FLUSH and HOLD. Registers are `state`, `owner`, `owner_vld`, `burst_cnt`, `rr_ptr`, `hold_cnt` and `flush_done`.
- `rr_pick` is the first index with `req_valid` set, searching from `rr_ptr` upward and wrapping modulo `N_REQ`. It is `rr_ptr` when no requester is valid.
- `cur` = `owner` when `owner_vld & req_valid[owner]`; otherwise `cur` = `rr_pick`.
- `xfer` = (state==RUN) & `req_valid[cur]` & !`pipe_out_stall`.
- `pipe_in_valid` = (state==RUN) & `req_valid[cur]`.
- `pipe_inputs` = `req_data[cur]`.
- `pipe_in_flush` = (state==FLUSH).
- `grant_id` = `cur`.
- `req_stall[i]` = `req_valid[i]` & !(`xfer` & `cur`==i).
- On `xfer`, a new burst starts when `owner_vld` is 0 or `cur` != `owner`. The new count is `n` = 1 for a new burst, else `burst_cnt`+1.
  - If `n`==`BURST`: `owner_vld`<=0, `burst_cnt`<=0, `rr_ptr`<=(`cur`+1) mod `N_REQ`.
  - Otherwise: `owner`<=`cur`, `owner_vld`<=1, `burst_cnt`<=`n`.
- When the owner drops valid (`owner_vld` & !`req_valid[owner]`) and there is no `xfer`: `owner_vld`<=0, `burst_cnt`<=0, `rr_ptr`<=(`owner`+1) mod `N_REQ`.
- When the owner drops valid and another requester transfers in the same cycle, the new-burst rule applies and `rr_ptr` is unchanged.
- `pipe_out_stall`=1 with the owner still valid: grant, `burst_cnt` and `rr_ptr` all hold.
- `BURST`=1 degenerates to pure per-transfer round-robin.
- Transitions:
  - RUN to FLUSH when `flush_req`=1.
  - FLUSH stays in FLUSH while `flush_req`=1. Otherwise it moves to HOLD with `hold_cnt`<=`HOLD_CYCLES`-1.
  - HOLD decrements `hold_cnt`. It moves to RUN when `hold_cnt`==0 and `flush_req`=0.
  - `flush_req`=1 in HOLD moves to FLUSH.
- Any entry into FLUSH clears `owner_vld` and `burst_cnt` and sets `rr_ptr` to 0.
- `flush_done`<=1 on the HOLD to RUN edge; otherwise 0.

## Timing
- Reset values: `state`=HOLD, `hold_cnt`=0, `owner_vld`=0, `burst_cnt`=0, `rr_ptr`=0, `flush_done`=0.
- Consequences of reset: `pipe_in_valid`=0, `pipe_in_flush`=0, and `req_stall`=`req_valid` while reset is asserted.
- The first rising edge after reset release moves HOLD to RUN. `flush_done` does not pulse after reset, only after a flush.
- Zero-cycle latency: data and valid to the head are combinational from requester inputs in RUN. A transfer completes on the edge at which `xfer`=1.
- A `flush_req` sampled high in RUN still completes that cycle's `xfer`. The flushed data is discarded by the chain.
- Flush sequence:
  - `pipe_in_flush` is high for 1 cycle, or longer while `flush_req` is held.
  - It is followed by exactly `HOLD_CYCLES` cycles with `pipe_in_valid`=0.
  - `flush_done` then pulses in the first RUN cycle.
- Asserting `reset` mid-burst or mid-flush returns to the reset state immediately. No partial pulse is guaranteed.
- With all requesters idle, `rr_ptr` holds and no state changes occur.

## Test plan
- Reset release with all 4 requesters valid, default parameters: cycle 1 is HOLD with `pipe_in_valid`=0. Then 4 transfers go to requester 0, then 4 to requester 1, with `grant_id` sequence 0,0,0,0,1,1,1,1.
- `BURST`=1, requesters 1 and 3 valid: grants alternate 1,3,1,3. `req_stall` is high on the non-granted requester each cycle.
- Requester 2 owns a burst with `burst_cnt`=2, then `pipe_out_stall`=1 for 3 cycles: `grant_id` stays 2, no `xfer` occurs and `burst_cnt` holds. After release the remaining 2 transfers go to requester 2, then the grant moves to 3.
- Owner 0 drops valid after 2 of 4 transfers while requesters 1 and 2 are valid: requester 1 transfers in the same cycle as a new burst. `rr_ptr` advances to 2 after requester 1's burst ends.
- `flush_req` held 1 cycle in RUN with `HOLD_CYCLES`=2:
  - That cycle's `xfer` occurs.
  - `pipe_in_flush`=1 for 1 cycle, followed by 2 cycles of `pipe_in_valid`=0.
  - `flush_done` pulses for 1 cycle, and the next grant goes to the lowest valid index.
- `flush_req` pulsed during HOLD: the FSM re-enters FLUSH, `pipe_in_flush` pulses again and the full hold window restarts.
